// File: rtl/fifo_rd_adapter.sv
// Read-side unloader for the registered-read FIFO: issues pops whenever there is room and
// presents the words on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_adapter #(
  parameter int unsigned width   = 4,
  parameter int unsigned count_w = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fifo_empty,
  input  logic [width-1:0]   fifo_data_out,
  output logic               fifo_r_en,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [width-1:0]   m_data,
  output logic               busy,
  output logic [count_w-1:0] out_count
);

  logic [width-1:0]   buf0_q, buf0_d;
  logic [width-1:0]   buf1_q, buf1_d;
  logic [1:0]         occ_q, occ_d;
  logic               inflight_q;
  logic [count_w-1:0] cnt_q, cnt_d;
  logic               pop;
  logic [1:0]         fill;
  logic [1:0]         occ_after_pop;

  always_comb begin
    pop           = (occ_q != 2'd0) && m_ready;
    // Words already committed to the buffer: held plus the one arriving next edge.
    fill          = occ_q + {1'b0, inflight_q};
    fifo_r_en     = rst && en && !fifo_empty && ((fill < 2'd2) || pop);
    occ_after_pop = occ_q - {1'b0, pop};

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    // The landing word takes the first slot left free once the pop has shifted the buffer.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = fifo_data_out;
      end else begin
        buf1_d = fifo_data_out;
      end
    end

    occ_d = occ_after_pop + {1'b0, inflight_q};
    cnt_d = cnt_q + count_w'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_r_en;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    m_valid   = (occ_q != 2'd0);
    m_data    = buf0_q;
    busy      = (occ_q != 2'd0) || inflight_q;
    out_count = cnt_q;
  end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: a behavioural registered-read FIFO feeds the DUT and a
// negedge monitor records reads, pops and delivered words.
module tb_fifo_rd_adapter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [3:0] fifo_data_out = 4'd0;
  logic       fifo_r_en;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic       busy;
  logic [3:0] out_count;

  fifo_rd_adapter #(
    .width   (4),
    .count_w (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_r_en     (fifo_r_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .busy          (busy),
    .out_count     (out_count)
  );

  always #5 clk = ~clk;

  // Behavioural 16-deep FIFO with one-cycle registered read.
  logic [3:0] fmem [16];
  logic [3:0] wp = 4'd0;
  logic [3:0] rp = 4'd0;
  logic [4:0] fcnt = 5'd0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = 4'd0;
  logic       rd_ok;

  assign fifo_empty = (fcnt == 5'd0);
  assign rd_ok      = fifo_r_en && (fcnt != 5'd0);

  always @(posedge clk) begin
    if (wr_en) begin
      fmem[wp] <= wr_data;
      wp       <= wp + 4'd1;
    end
    if (rd_ok) begin
      fifo_data_out <= fmem[rp];
      rp            <= rp + 4'd1;
    end
    fcnt <= fcnt + 5'(wr_en) - 5'(rd_ok);
  end

  // Monitor: inputs change just after posedge, so negedge sees what the next edge will act on.
  int         rd_pulses = 0;
  int         out_n = 0;
  int         viol_occ = 0;
  int         viol_empty = 0;
  logic [3:0] got[$];

  always @(negedge clk) begin
    if (fifo_r_en) rd_pulses++;
    if (fifo_r_en && fifo_empty) viol_empty++;
    if (!rst) begin
      out_n = 0;
    end else begin
      out_n = out_n + int'(fifo_r_en) - int'(m_valid && m_ready);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    if (out_n > 2) viol_occ++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic wait_deliv(input string tag, input int target, input int max);
    int k = 0;
    while (got.size() < target && k < max) begin
      cyc();
      k++;
    end
    chk(tag, 32'(got.size()), 32'(target));
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy && k < max) begin
      cyc();
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  int base;
  int pulses0;

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    cyc();
    cyc();

    // Reset holds everything quiet even with en high and a loaded FIFO.
    push(4'h3);
    push(4'h6);
    push(4'h9);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_r_en", 32'(fifo_r_en), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      cyc();
    end
    base    = got.size();
    rst     = 1'b1;
    m_ready = 1'b1;
    wait_deliv("rst_release_deliv", base + 3, 20);
    chk("rst_release_w0", 32'(got[base]), 32'h3);
    chk("rst_release_w2", 32'(got[base + 2]), 32'h9);
    wait_idle("rst_release_idle", 10);

    // Streaming 1..8 with m_ready high.
    do_reset();
    for (int i = 1; i <= 8; i++) push(4'(i));
    m_ready = 1'b1;
    #1;
    chk("stream_no_read_en_low", 32'(fifo_r_en), 32'd0);
    base = got.size();
    en   = 1'b1;
    #1;
    chk("stream_r_en", 32'(fifo_r_en), 32'd1);
    cyc();
    chk("stream_latency", 32'(m_valid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("stream_word", 32'({m_valid, m_data}), 32'({1'b1, 4'(i)}));
    end
    cyc();
    chk("stream_end_valid", 32'(m_valid), 32'd0);
    chk("stream_end_busy", 32'(busy), 32'd0);
    chk("stream_count", 32'(out_count), 32'd8);
    en = 1'b0;

    // Backpressure: five words, consumer stalled for six cycles.
    do_reset();
    for (int i = 0; i < 5; i++) push(4'hA + 4'(i));
    base    = got.size();
    pulses0 = rd_pulses;
    en      = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i >= 2) chk("bp_hold", 32'({m_valid, m_data}), 32'({1'b1, 4'hA}));
    end
    chk("bp_reads_stalled", 32'(rd_pulses - pulses0), 32'd2);
    m_ready = 1'b1;
    wait_deliv("bp_deliv", base + 5, 30);
    for (int i = 0; i < 5; i++) chk("bp_order", 32'(got[base + i]), 32'(4'hA + 4'(i)));
    wait_idle("bp_idle", 10);
    chk("bp_no_overfill", 32'(viol_occ), 32'd0);
    en = 1'b0;

    // Single word: exactly one read, busy drops one cycle after the pop.
    do_reset();
    push(4'h5);
    base    = got.size();
    pulses0 = rd_pulses;
    en      = 1'b1;
    m_ready = 1'b1;
    cyc();
    chk("one_busy_inflight", 32'({busy, m_valid}), 32'({1'b1, 1'b0}));
    cyc();
    chk("one_word", 32'({m_valid, m_data, busy}), 32'({1'b1, 4'h5, 1'b1}));
    cyc();
    chk("one_after_pop", 32'({m_valid, busy}), 32'd0);
    cyc();
    cyc();
    chk("one_reads", 32'(rd_pulses - pulses0), 32'd1);
    chk("one_delivered", 32'(got.size() - base), 32'd1);
    chk("one_no_read_empty", 32'(viol_empty), 32'd0);
    en = 1'b0;

    // en dropped after four reads from a full FIFO.
    do_reset();
    for (int i = 0; i < 16; i++) push(4'(i));
    base    = got.size();
    pulses0 = rd_pulses;
    en      = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    en = 1'b0;
    chk("endrop_reads", 32'(rd_pulses - pulses0), 32'd4);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("endrop_r_en_low", 32'(fifo_r_en), 32'd0);
      cyc();
    end
    chk("endrop_delivered", 32'(got.size() - base), 32'd4);
    chk("endrop_fifo_left", 32'(fcnt), 32'd12);
    chk("endrop_busy", 32'(busy), 32'd0);
    en = 1'b1;
    wait_deliv("endrop_deliv", base + 16, 40);
    for (int i = 0; i < 16; i++) chk("endrop_order", 32'(got[base + i]), 32'(i));
    wait_idle("endrop_idle", 10);
    en = 1'b0;

    // Counter wrap at 16, then reset with a read in flight.
    do_reset();
    for (int i = 0; i < 16; i++) push(4'(15 - i));
    base    = got.size();
    en      = 1'b1;
    m_ready = 1'b1;
    wait_deliv("wrap_deliv", base + 16, 40);
    wait_idle("wrap_idle", 10);
    chk("wrap_count16", 32'(out_count), 32'd0);
    en = 1'b0;
    push(4'h9);
    push(4'hA);
    push(4'hB);
    en = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("wrap_count17", 32'(out_count), 32'd1);
    chk("wrap_head", 32'({m_valid, m_data, busy}), 32'({1'b1, 4'hA, 1'b1}));
    rst = 1'b0;
    #1;
    chk("midrst_r_en", 32'(fifo_r_en), 32'd0);
    cyc();
    chk("midrst_state", 32'({m_valid, m_data, busy}), 32'd0);
    chk("midrst_count", 32'(out_count), 32'd0);
    base = got.size();
    rst  = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("midrst_no_ghost", 32'(got.size() - base), 32'd0);
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("final_no_read_empty", 32'(viol_empty), 32'd0);
    chk("final_no_overfill", 32'(viol_occ), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_adapter.md
Name: fifo_rd_adapter

Overview:
- Read-side unloader for the team's FIFO block (r_en / data_out / empty interface, registered read with 1-cycle latency).
- Pops words whenever the FIFO is non-empty and there is room.
- Presents the words on a valid/ready stream, with a 2-entry skid buffer that absorbs the in-flight read.
- Sits between the FIFO and any downstream consumer; replaces the ad-hoc read driver with a reusable, full-throughput read master.

Parameters:
- width, 4, data word width; must match the FIFO width.
- count_w, 8, width of the delivered-word counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  when high, the block may issue FIFO reads; when low, no new reads are issued.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  width  FIFO read data; valid in the cycle after r_en was high.
- fifo_r_en  output  1  FIFO read enable; combinational.
- m_valid  output  1  output word available; registered.
- m_ready  input  1  consumer accepts the word when m_valid && m_ready at a clock edge.
- m_data  output  width  output word; registered.
- busy  output  1  high when occ != 0 or inflight.
- out_count  output  count_w  number of words delivered, modulo 2^count_w.

Behaviour:
- State:
  - buf[0..1]: skid buffer; buf[0] is the head.
  - occ: occupancy, 0..2.
  - inflight: 1 bit; the FIFO read issued in the previous cycle.
  - out_count.
- Reset (rst low at a clock edge):
  - occ=0, inflight=0, m_valid=0, m_data=0, out_count=0, busy=0.
  - fifo_r_en is forced 0 while rst is low.
  - A read in flight at reset is discarded; that FIFO word is lost (accepted behaviour).
- pop = m_valid && m_ready.
- fifo_r_en = rst && en && !fifo_empty && ((occ + inflight) < 2 || pop).
  - Combinational paths from m_ready and fifo_empty are allowed.
  - The invariant occ + inflight <= 2 must always hold.
  - fifo_r_en is never asserted while fifo_empty=1.
- Each clock edge:
  - inflight_next = fifo_r_en.
  - If inflight, fifo_data_out is captured this edge.
  - occ_next = occ + inflight - pop.
- Buffer ordering (strict FIFO order):
  - A captured word goes to the first free slot after the pop is applied.
  - On pop, buf[1] shifts to buf[0].
  - Simultaneous pop and capture with occ=1: the captured word becomes the new head.
  - Simultaneous pop and capture with occ=2: buf[1] becomes the head, and the captured word goes to buf[1].
- Output:
  - m_valid = (occ != 0) and m_data = buf[0], both from registers.
  - m_data holds stable while m_valid && !m_ready.
  - m_valid never drops without a pop.
- Latency:
  - FIFO non-empty at edge N with fifo_r_en high gives m_valid high after edge N+1.
  - First word reaches the output 2 cycles after en rises with a non-empty FIFO.
- Throughput: with m_ready held high, one word per cycle is sustained (occ=1, inflight=1 steady state).
- Backpressure:
  - m_ready low stops reads once occ + inflight = 2.
  - No overflow; no word is dropped or duplicated.
- en low:
  - No new reads.
  - An in-flight word still lands.
  - Buffered words still drain.
  - busy falls once occ=0 and inflight=0.
- fifo_empty mid-burst:
  - Reads stop that cycle; the in-flight word still lands.
  - Reads resume the cycle fifo_empty deasserts.
- out_count increments by 1 on each pop and wraps from 2^count_w-1 to 0.

Test Plan:
- Reset: rst=0 for 2 cycles while en=1 and the FIFO holds 3 words → fifo_r_en=0, m_valid=0, m_data=0, out_count=0 throughout reset.
- Streaming: write 0x1..0x8 into the FIFO, m_ready=1, then en=1 → m_data sequence 1..8 on 8 consecutive cycles; first m_valid 2 cycles after en; out_count=8; busy=0 afterwards.
- Backpressure: write 5 words, en=1, m_ready=0 for 6 cycles, then 1 → exactly 2 fifo_r_en pulses while stalled; m_data held at word 0; all 5 delivered in order; never occ+inflight>2.
- Empty boundary: FIFO holds 1 word, en=1 → exactly one fifo_r_en pulse; no r_en while empty; m_valid for one handshake; busy drops 1 cycle after the pop.
- en drop mid-burst: FIFO holds 16 words (full); deassert en after 4 reads issued → exactly 4 words delivered; FIFO retains 12; fifo_r_en stays 0 until en returns; the remaining 12 follow in order.
- Counter wrap and reset mid-stream: with count_w=4, deliver 17 words → out_count=1. Then rst=0 with inflight=1 → occ=0 and m_valid=0 next cycle; the in-flight word is not presented after reset.
